// File: rtl/result_tx_serializer.sv
// Result transmit serializer: snapshots a vector or scalar result on request and
// streams it MSB-first, byte by byte, to a UART transmitter using a start/busy
// handshake. Signals completion with a one-cycle tx_sent pulse.
module result_tx_serializer #(
    parameter int unsigned NINPUTS        = 8,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned BYTES_PER_WORD = 4    // 1 .. WORD_W/8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           begin_transmission,
    input  logic                           send_vector,
    input  logic [NINPUTS-1:0][WORD_W-1:0] par_result,
    input  logic [WORD_W-1:0]              man_result,
    input  logic                           tx_busy,
    output logic [7:0]                     tx_data,
    output logic                           tx_start,
    output logic                           tx_sent,
    output logic                           busy
);

    localparam int unsigned IdxW  = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
    localparam int unsigned CntW  = $clog2(NINPUTS + 1);
    localparam int unsigned ByteW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitAck,
        StWaitDone,
        StFinish
    } state_e;

    state_e                         state_q, state_d;
    logic [NINPUTS-1:0][WORD_W-1:0] snap_q, snap_d;
    logic [CntW-1:0]                word_count_q, word_count_d;
    logic [IdxW-1:0]                word_idx_q, word_idx_d;
    logic [ByteW-1:0]               byte_idx_q, byte_idx_d;
    logic [7:0]                     tx_data_q, tx_data_d;
    logic                           tx_start_q, tx_start_d;
    logic                           tx_sent_q, tx_sent_d;
    logic                           busy_q, busy_d;

    logic [WORD_W-1:0]              cur_word;
    logic [7:0]                     cur_byte;
    logic                           last_byte_of_word;
    logic                           last_word;

    // Select the current byte of the snapshot: byte index 0 is the most significant sent byte.
    always_comb begin
        cur_word = snap_q[word_idx_q];
        cur_byte = '0;
        for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
            if (byte_idx_q == ByteW'(b)) begin
                cur_byte = cur_word[8*(BYTES_PER_WORD-b)-1 -: 8];
            end
        end
        last_byte_of_word = (byte_idx_q == ByteW'(BYTES_PER_WORD - 1));
        last_word         = ((CntW'(word_idx_q) + CntW'(1)) == word_count_q);
    end

    // Next-state and registered-output logic for the transmit FSM.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        tx_sent_d    = 1'b0;
        busy_d       = busy_q;

        unique case (state_q)
            StIdle: begin
                if (begin_transmission) begin
                    if (send_vector) begin
                        snap_d       = par_result;
                        word_count_d = CntW'(NINPUTS);
                    end else begin
                        snap_d       = '0;
                        snap_d[0]    = man_result;
                        word_count_d = CntW'(1);
                    end
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                // Never strobe while the UART is still busy with something else.
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (last_byte_of_word && last_word) begin
                        tx_sent_d = 1'b1;
                        state_d   = StFinish;
                    end else begin
                        if (last_byte_of_word) begin
                            byte_idx_d = '0;
                            word_idx_d = word_idx_q + IdxW'(1);
                        end else begin
                            byte_idx_d = byte_idx_q + ByteW'(1);
                        end
                        state_d = StStart;
                    end
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            snap_q       <= '0;
            word_count_q <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_sent_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            tx_sent_q    <= tx_sent_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign tx_sent  = tx_sent_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_result_tx_serializer.sv
// Directed bench for result_tx_serializer with a mock UART that holds busy for
// three cycles after each start strobe.
module tb_result_tx_serializer;

    localparam int unsigned NIN = 8;
    localparam int unsigned W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic                     begin_tx;
    logic                     send_vec;
    logic [NIN-1:0][W-1:0]    par;
    logic [W-1:0]             man;
    logic                     hold_busy;
    logic                     mock_busy = 1'b0;
    int                       mock_cnt  = 0;
    logic                     tx_busy;
    logic [7:0]               tx_data;
    logic                     tx_start;
    logic                     tx_sent;
    logic                     busy;

    // Second instance with two bytes per word.
    logic                     begin_tx2;
    logic [W-1:0]             man2;
    logic                     mock2_busy = 1'b0;
    int                       mock2_cnt  = 0;
    logic [7:0]               tx_data2;
    logic                     tx_start2;
    logic                     tx_sent2;
    logic                     busy2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] bytes_q[$];
    int         sent_cnt = 0;
    logic [7:0] bytes2_q[$];
    int         sent2_cnt = 0;

    assign tx_busy = mock_busy | hold_busy;

    result_tx_serializer #(
        .NINPUTS(NIN), .WORD_W(W), .BYTES_PER_WORD(4)
    ) dut (
        .clk(clk), .reset(reset), .begin_transmission(begin_tx), .send_vector(send_vec),
        .par_result(par), .man_result(man), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_start(tx_start), .tx_sent(tx_sent), .busy(busy)
    );

    result_tx_serializer #(
        .NINPUTS(NIN), .WORD_W(W), .BYTES_PER_WORD(2)
    ) dut2 (
        .clk(clk), .reset(reset), .begin_transmission(begin_tx2), .send_vector(1'b0),
        .par_result(par), .man_result(man2), .tx_busy(mock2_busy), .tx_data(tx_data2),
        .tx_start(tx_start2), .tx_sent(tx_sent2), .busy(busy2)
    );

    // Mock UARTs: busy for three cycles after each start strobe.
    always @(posedge clk) begin
        if (tx_start) begin
            mock_busy <= 1'b1;
            mock_cnt  <= 3;
        end else if (mock_cnt > 0) begin
            mock_cnt <= mock_cnt - 1;
            if (mock_cnt == 1) mock_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tx_start2) begin
            mock2_busy <= 1'b1;
            mock2_cnt  <= 3;
        end else if (mock2_cnt > 0) begin
            mock2_cnt <= mock2_cnt - 1;
            if (mock2_cnt == 1) mock2_busy <= 1'b0;
        end
    end

    // Byte/pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start) bytes_q.push_back(tx_data);
        if (tx_sent) sent_cnt++;
        if (tx_start2) bytes2_q.push_back(tx_data2);
        if (tx_sent2) sent2_cnt++;
    end

    task automatic clear_mon();
        bytes_q.delete();
        sent_cnt = 0;
        bytes2_q.delete();
        sent2_cnt = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits for tx_sent; cycles = -1 on timeout. Counts cycles with busy low meanwhile.
    task automatic wait_sent(input int max, output int cycles, output int busy_low);
        cycles   = -1;
        busy_low = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (tx_sent) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        begin_tx  = 1'b0;
        begin_tx2 = 1'b0;
        send_vec  = 1'b0;
        hold_busy = 1'b0;
        par       = '0;
        man       = '0;
        man2      = '0;
        idle_cycles(3);
        checks++;
        if ({tx_data, tx_start, tx_sent, busy} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000", {tx_data, tx_start, tx_sent, busy});
        end
        checks++;
        if ({tx_data2, tx_start2, tx_sent2, busy2} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs2 got=%h want=000",
                     {tx_data2, tx_start2, tx_sent2, busy2});
        end
        reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_scalar();
        logic [7:0] exp [4] = '{8'h00, 8'h00, 8'h01, 8'h2C};
        logic [7:0] got;
        int cyc, blow;
        clear_mon();
        man      = 32'h0000_012C;
        send_vec = 1'b0;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL scalar_snapshot busy=%b start=%b want busy=1 start=0", busy, tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL scalar_first_start start=%b data=%h want start=1 data=00",
                     tx_start, tx_data);
        end
        wait_sent(200, cyc, blow);
        checks++;
        if (cyc < 0) begin
            failures++;
            $display("FAIL scalar_timeout got=none want=tx_sent");
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL scalar_busy_at_sent got=%b want=1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_sent !== 1'b0) begin
            failures++;
            $display("FAIL scalar_after_finish busy=%b sent=%b want 0 0", busy, tx_sent);
        end
        idle_cycles(5);
        checks++;
        if (bytes_q.size() != 4 || sent_cnt != 1) begin
            failures++;
            $display("FAIL scalar_counts bytes=%0d sent=%0d want 4 1", bytes_q.size(), sent_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL scalar_byte%0d got=%h want=%h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_vector();
        logic [7:0] got, want;
        int cyc, blow;
        clear_mon();
        for (int i = 0; i < int'(NIN); i++) par[i] = 32'(10 + 2 * i);
        send_vec = 1'b1;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        wait_sent(1000, cyc, blow);
        checks++;
        if (cyc < 0 || blow != 0) begin
            failures++;
            $display("FAIL vector_busy_through cyc=%0d busy_low=%0d want sent and 0", cyc, blow);
        end
        idle_cycles(5);
        checks++;
        if (bytes_q.size() != 32 || sent_cnt != 1) begin
            failures++;
            $display("FAIL vector_counts bytes=%0d sent=%0d want 32 1", bytes_q.size(), sent_cnt);
        end
        checks++;
        if (bytes_q.size() == 32 && (bytes_q[3] !== 8'h0A || bytes_q[7] !== 8'h0C ||
                                     bytes_q[31] !== 8'h18)) begin
            failures++;
            $display("FAIL vector_spot b3=%h b7=%h b31=%h want 0a 0c 18",
                     bytes_q[3], bytes_q[7], bytes_q[31]);
        end
        for (int j = 0; j < 32; j++) begin
            want = (j % 4 == 3) ? 8'(10 + 2 * (j / 4)) : 8'h00;
            got  = (j < bytes_q.size()) ? bytes_q[j] : 8'hxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL vector_byte%0d got=%h want=%h", j, got, want);
            end
        end
        send_vec = 1'b0;
    endtask

    task automatic test_isolation();
        logic [7:0] got, want;
        int cyc, blow;
        clear_mon();
        for (int i = 0; i < int'(NIN); i++) par[i] = {8'(i), 8'hA5, 8'h5A, 8'(3 * i)};
        send_vec = 1'b1;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        @(negedge clk);
        for (int i = 0; i < int'(NIN); i++) par[i] = 32'hFFFF_FFFF;
        wait_sent(1000, cyc, blow);
        idle_cycles(3);
        checks++;
        if (cyc < 0 || bytes_q.size() != 32) begin
            failures++;
            $display("FAIL isolation_counts cyc=%0d bytes=%0d want sent 32", cyc, bytes_q.size());
        end
        for (int j = 0; j < 32; j++) begin
            unique case (j % 4)
                0:       want = 8'(j / 4);
                1:       want = 8'hA5;
                2:       want = 8'h5A;
                default: want = 8'(3 * (j / 4));
            endcase
            got = (j < bytes_q.size()) ? bytes_q[j] : 8'hxx;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL isolation_byte%0d got=%h want=%h", j, got, want);
            end
        end
        send_vec = 1'b0;
    endtask

    task automatic test_interlock();
        logic [7:0] exp [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        logic [7:0] got;
        int starts, cyc, blow;
        clear_mon();
        man       = 32'hCAFE_F00D;
        hold_busy = 1'b1;
        begin_tx  = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        idle_cycles(10);
        checks++;
        if (bytes_q.size() != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL interlock_hold starts=%0d busy=%b want 0 1", bytes_q.size(), busy);
        end
        hold_busy = 1'b0;
        starts    = 0;
        for (int i = 0; i < 100 && starts < 2; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        // Request a vector send mid-transfer; it must be ignored.
        send_vec = 1'b1;
        man      = 32'h1111_1111;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        send_vec = 1'b0;
        wait_sent(300, cyc, blow);
        idle_cycles(20);
        checks++;
        if (cyc < 0 || bytes_q.size() != 4 || sent_cnt != 1) begin
            failures++;
            $display("FAIL interlock_counts cyc=%0d bytes=%0d sent=%0d want 4 1",
                     cyc, bytes_q.size(), sent_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL interlock_byte%0d got=%h want=%h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] got;
        int starts, cyc, blow;
        clear_mon();
        man      = 32'h0102_0304;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        starts   = 0;
        for (int i = 0; i < 100 && starts < 2; i++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_data, tx_start, tx_sent, busy} !== 11'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=000", {tx_data, tx_start, tx_sent, busy});
        end
        reset = 1'b1;
        idle_cycles(30);
        checks++;
        if (sent_cnt != 0 || bytes_q.size() != 2) begin
            failures++;
            $display("FAIL midreset_abort sent=%0d bytes=%0d want 0 2", sent_cnt, bytes_q.size());
        end
        clear_mon();
        man      = 32'hDEAD_BEEF;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        wait_sent(300, cyc, blow);
        idle_cycles(3);
        checks++;
        if (cyc < 0 || bytes_q.size() != 4) begin
            failures++;
            $display("FAIL midreset_resend cyc=%0d bytes=%0d want sent 4", cyc, bytes_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL midreset_byte%0d got=%h want=%h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, blow;
        clear_mon();
        man      = 32'h0000_00AA;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        wait_sent(300, cyc, blow);
        // Next negedge is the first idle cycle; request then.
        @(negedge clk);
        man      = 32'h0000_00BB;
        begin_tx = 1'b1;
        @(negedge clk);
        begin_tx = 1'b0;
        checks++;
        if (cyc < 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept cyc=%0d busy=%b want sent 1", cyc, busy);
        end
        wait_sent(300, cyc, blow);
        idle_cycles(3);
        checks++;
        if (cyc < 0 || bytes_q.size() != 8 || sent_cnt != 2) begin
            failures++;
            $display("FAIL b2b_counts bytes=%0d sent=%0d want 8 2", bytes_q.size(), sent_cnt);
        end
        checks++;
        if (bytes_q.size() == 8 && (bytes_q[3] !== 8'hAA || bytes_q[7] !== 8'hBB)) begin
            failures++;
            $display("FAIL b2b_bytes b3=%h b7=%h want aa bb", bytes_q[3], bytes_q[7]);
        end
    endtask

    task automatic test_bpw2();
        int cyc;
        clear_mon();
        man2      = 32'h1234_5678;
        begin_tx2 = 1'b1;
        @(negedge clk);
        begin_tx2 = 1'b0;
        cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_sent2) begin
                cyc = i;
                break;
            end
        end
        idle_cycles(5);
        checks++;
        if (cyc < 0 || bytes2_q.size() != 2 || sent2_cnt != 1) begin
            failures++;
            $display("FAIL bpw2_counts cyc=%0d bytes=%0d sent=%0d want 2 1",
                     cyc, bytes2_q.size(), sent2_cnt);
        end
        checks++;
        if (bytes2_q.size() == 2 && (bytes2_q[0] !== 8'h56 || bytes2_q[1] !== 8'h78)) begin
            failures++;
            $display("FAIL bpw2_bytes got=%h %h want=56 78", bytes2_q[0], bytes2_q[1]);
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_vector();
        test_isolation();
        test_interlock();
        test_reset_mid();
        test_back_to_back();
        test_bpw2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
